// File: rtl/wdt_kick_scheduler_pkg.sv
// Shared encodings for the watchdog kick scheduler: FSM states, register
// addresses and the bus slot the scheduler's watchdog lives at.
package wdt_kick_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_KICK    = 2'd2,
    ST_STARVED = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_RELOAD = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  // Base address of the hardware watchdog this scheduler kicks.
  localparam logic [31:0] WDT_SLOT_ADDR = 32'h4000_0400;

  // Arming needs a non-empty task set, a reload value and a window length.
  function automatic logic arm_allowed(input logic mask_nz,
                                       input logic [31:0] reload,
                                       input logic [31:0] period);
    return mask_nz && (reload != 32'd0) && (period != 32'd0);
  endfunction

endpackage

// File: rtl/wdt_kick_scheduler_if.sv
// Configuration bus between the CPU-side register master and the scheduler.
interface wdt_kick_scheduler_if;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/wdt_window_timer.sv
// Microsecond window counter: cleared by the FSM, advanced on enabled ticks,
// flags the tick that completes the programmed window.
module wdt_window_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        expire
);

  logic [31:0] count_reg;

  // Saturates instead of wrapping so a stale window can never re-expire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= 32'd0;
    else if (clear)
      count_reg <= 32'd0;
    else if (enable && (count_reg != 32'hFFFF_FFFF))
      count_reg <= count_reg + 32'd1;
  end

  assign expire = enable && (count_reg == (period - 32'd1));

endmodule

// File: rtl/wdt_kick_scheduler.sv
// Heartbeat aggregator: kicks the watchdog only after every enabled task has
// checked in within the window; a missed window latches starved forever.
module wdt_kick_scheduler
  import wdt_kick_scheduler_pkg::*;
#(
  parameter int N_TASKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1us,
  input  logic [N_TASKS-1:0]   heartbeat,
  wdt_kick_scheduler_if.slave  cfg,
  output logic                 kick,
  output logic [31:0]          kick_value,
  output logic                 starved
);

  state_t               state_reg, state_next;
  logic [N_TASKS-1:0]   mask_reg, pending_reg, pending_next, missed_reg, missed_next;
  logic [31:0]          reload_reg, period_reg;
  logic [N_TASKS-1:0]   live;
  logic                 all_in, arm_req, in_idle, timer_clear, timer_enable, expire;
  logic [31:0]          ctrl_word;

  assign in_idle = (state_reg == ST_IDLE);
  assign arm_req = cfg.cfg_we && (cfg.cfg_addr == ADDR_CTRL) && cfg.cfg_wdata[0]
                   && arm_allowed(mask_reg != '0, reload_reg, period_reg);

  // Heartbeats landing on this edge count toward completion immediately.
  assign live   = (pending_reg | heartbeat) & mask_reg;
  assign all_in = (live == mask_reg);

  assign timer_enable = (state_reg == ST_COLLECT) && tick_1us;

  wdt_window_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .period (period_reg),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      missed_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      missed_reg  <= missed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    missed_next  = missed_reg;
    timer_clear  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (arm_req)
          state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        pending_next = live;
        // Completion takes priority over a timeout on the same edge.
        if (all_in) begin
          state_next = ST_KICK;
        end else if (expire) begin
          missed_next = mask_reg & ~live;
          state_next  = ST_STARVED;
        end
      end
      ST_KICK: begin
        pending_next = heartbeat & mask_reg;
        timer_clear  = 1'b1;
        state_next   = ST_COLLECT;
      end
      ST_STARVED: begin
        state_next = ST_STARVED;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Register file: MASK/PERIOD lock once armed, RELOAD stays writable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg   <= '0;
      reload_reg <= 32'd0;
      period_reg <= 32'd0;
    end else if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        ADDR_MASK:   if (in_idle) mask_reg <= cfg.cfg_wdata[N_TASKS-1:0];
        ADDR_RELOAD: reload_reg <= cfg.cfg_wdata;
        ADDR_PERIOD: if (in_idle) period_reg <= cfg.cfg_wdata;
        default: ;
      endcase
    end
  end

  assign ctrl_word[1:0] = state_reg;
  assign ctrl_word[3:2] = 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pend_field
      if (gi < N_TASKS) begin : g_used
        assign ctrl_word[4+gi] = pending_reg[gi];
      end else begin : g_pad
        assign ctrl_word[4+gi] = 1'b0;
      end
    end
    for (gi = 0; gi < 24; gi++) begin : g_miss_field
      if (gi < N_TASKS) begin : g_used
        assign ctrl_word[8+gi] = missed_reg[gi];
      end else begin : g_pad
        assign ctrl_word[8+gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    cfg.cfg_rdata = 32'd0;
    case (cfg.cfg_addr)
      ADDR_CTRL:   cfg.cfg_rdata = ctrl_word;
      ADDR_MASK:   cfg.cfg_rdata = {{(32-N_TASKS){1'b0}}, mask_reg};
      ADDR_RELOAD: cfg.cfg_rdata = reload_reg;
      ADDR_PERIOD: cfg.cfg_rdata = period_reg;
      default:     cfg.cfg_rdata = 32'd0;
    endcase
  end

  assign kick       = (state_reg == ST_KICK);
  assign starved    = (state_reg == ST_STARVED);
  assign kick_value = reload_reg;

endmodule

// File: tb/tb_wdt_kick_scheduler.sv
// Directed bench for the watchdog kick scheduler with hand-computed expectations.
module tb_wdt_kick_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1us = 1'b0;
  logic [3:0]  heartbeat = 4'b0000;
  logic        kick;
  logic [31:0] kick_value;
  logic        starved;

  int errors = 0;
  int checks = 0;

  wdt_kick_scheduler_if bus ();

  wdt_kick_scheduler #(.N_TASKS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1us   (tick_1us),
    .heartbeat  (heartbeat),
    .cfg        (bus),
    .kick       (kick),
    .kick_value (kick_value),
    .starved    (starved)
  );

  always #20 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1us = 1'b1;
      step();
      tick_1us = 1'b0;
      step();
    end
  endtask

  logic [31:0] r;

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    rd(2'd0, r); check_val("reset_ctrl", r, 32'h0);
    rd(2'd1, r); check_val("reset_mask", r, 32'h0);
    check_val("reset_kick", {31'd0, kick}, 32'd0);
    check_val("reset_starved", {31'd0, starved}, 32'd0);
    check_val("reset_kick_value", kick_value, 32'd0);

    // Arm with MASK=0 is refused
    wr(2'd2, 32'd1000);
    wr(2'd3, 32'd50);
    wr(2'd0, 32'd1);
    rd(2'd0, r); check_val("arm_mask0_state", r, 32'h0);

    wr(2'd1, 32'h3);
    wr(2'd0, 32'd1);
    rd(2'd0, r); check_val("arm_ok_state", r, 32'h1);

    // Completion: hb0 then hb1 three cycles later
    heartbeat = 4'b0001; step(); heartbeat = 4'b0000;
    rd(2'd0, r); check_val("pending_hb0", r, 32'h11);
    step(); step();
    heartbeat = 4'b0010; step(); heartbeat = 4'b0000;
    check_val("kick_pulse", {31'd0, kick}, 32'd1);
    check_val("kick_value_1000", kick_value, 32'd1000);
    rd(2'd0, r); check_val("kick_state_ctrl", r, 32'h32);
    step();
    check_val("kick_one_cycle", {31'd0, kick}, 32'd0);
    rd(2'd0, r); check_val("pending_cleared", r, 32'h1);

    // Locking of MASK/PERIOD, RELOAD still writable, unmasked heartbeat ignored
    wr(2'd1, 32'hF);
    rd(2'd1, r); check_val("mask_locked", r, 32'h3);
    wr(2'd3, 32'd7);
    rd(2'd3, r); check_val("period_locked", r, 32'd50);
    wr(2'd2, 32'd2000);
    rd(2'd2, r); check_val("reload_written", r, 32'd2000);
    heartbeat = 4'b1000; step(); heartbeat = 4'b0000;
    rd(2'd0, r); check_val("unmasked_hb_ignored", r, 32'h1);
    check_val("unmasked_no_kick", {31'd0, kick}, 32'd0);

    // Completion on the same edge as the 50th tick beats the timeout
    heartbeat = 4'b0001; step(); heartbeat = 4'b0000;
    ticks(49);
    rd(2'd0, r); check_val("before_tick50", r, 32'h11);
    tick_1us = 1'b1; heartbeat = 4'b0010; step();
    tick_1us = 1'b0; heartbeat = 4'b0000;
    check_val("simul_kick", {31'd0, kick}, 32'd1);
    check_val("simul_not_starved", {31'd0, starved}, 32'd0);
    check_val("kick_value_2000", kick_value, 32'd2000);
    // hb0 during the KICK cycle carries into the next round
    heartbeat = 4'b0001; step(); heartbeat = 4'b0000;
    check_val("post_kick_low", {31'd0, kick}, 32'd0);
    rd(2'd0, r); check_val("hb_in_kick_pending", r, 32'h11);

    // Window miss: hb1 never arrives
    ticks(49);
    check_val("miss_not_yet", {31'd0, starved}, 32'd0);
    tick_1us = 1'b1; step(); tick_1us = 1'b0;
    check_val("starved_set", {31'd0, starved}, 32'd1);
    check_val("starved_no_kick", {31'd0, kick}, 32'd0);
    rd(2'd0, r); check_val("starved_ctrl", r, 32'h213);
    heartbeat = 4'b0010; step(); heartbeat = 4'b0000;
    step(); step();
    check_val("starved_terminal_kick", {31'd0, kick}, 32'd0);
    rd(2'd0, r); check_val("starved_terminal_ctrl", r, 32'h213);

    // Asynchronous reset out of STARVED
    #5 rst = 1'b1; #1;
    check_val("arst_starved_clear", {31'd0, starved}, 32'd0);
    rd(2'd0, r); check_val("arst_ctrl", r, 32'h0);
    check_val("arst_kick_value", kick_value, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Asynchronous reset mid-COLLECT
    wr(2'd2, 32'd1000);
    wr(2'd3, 32'd50);
    wr(2'd1, 32'h3);
    wr(2'd0, 32'd1);
    heartbeat = 4'b0001; step(); heartbeat = 4'b0000;
    rd(2'd0, r); check_val("rearm_pending", r, 32'h11);
    #5 rst = 1'b1; #1;
    rd(2'd0, r); check_val("arst_collect_ctrl", r, 32'h0);
    check_val("arst_collect_kick", {31'd0, kick}, 32'd0);
    check_val("arst_collect_starved", {31'd0, starved}, 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wdt_kick_scheduler.md
# wdt_kick_scheduler

Heartbeat aggregator and kick sequencer for the hardware watchdog timer. Up to N software or hardware tasks each pulse a heartbeat. The scheduler issues one watchdog kick only after every enabled task has checked in within a programmed window, so a single live task cannot keep a hung system alive. It sits between the peripheral bus and the watchdog's kick/kick_value inputs, and shares the same 1 MHz tick_1us.

## Interface
- N_TASKS, 4: number of heartbeat sources (1..8)
- clk  in  1  system clock (25 MHz)
- rst  in  1  asynchronous, active-high reset
- tick_1us  in  1  one-cycle 1 MHz strobe
- heartbeat  in  N_TASKS  one-cycle check-in pulses, one bit per task
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  register select: 0 CTRL, 1 MASK, 2 RELOAD, 3 PERIOD
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data for cfg_addr (combinational)
- kick  out  1  one-cycle kick to watchdog; reset 0
- kick_value  out  32  value loaded into watchdog, equals RELOAD; reset 0
- starved  out  1  sticky window-miss flag / interrupt; reset 0

## Operation
- Registers reset to 0: MASK[N_TASKS-1:0], RELOAD[31:0], PERIOD[31:0] (µs), pending[N_TASKS-1:0], missed[N_TASKS-1:0], window counter[31:0].
- MASK and PERIOD are writable only in state IDLE. Writes in any other state are ignored. RELOAD is writable at any time.
- Write to CTRL with bit0=1 in IDLE arms the scheduler, provided MASK!=0, RELOAD!=0 and PERIOD!=0. Otherwise the write is ignored. Arming is irreversible until rst.
- CTRL read: {missed[N+7:8] at bits 8+, pending at bits 7:4 (zero-extended), state at bits 1:0}. Other addresses read back their register.
- States:
  - IDLE(0): kick=0, counter held at 0, heartbeats ignored. On a valid arm, go to COLLECT.
  - COLLECT(1): pending |= heartbeat & MASK on each edge. The counter increments on tick_1us.
    - If (pending | heartbeat) & MASK == MASK, go to KICK.
    - Else, if tick_1us and counter == PERIOD-1: missed <= MASK & ~(pending|heartbeat), go to STARVED.
    - If completion and timeout occur on the same edge, completion wins.
  - KICK(2): kick=1 for exactly this cycle, with kick_value=RELOAD. At the end of the cycle: pending <= heartbeat & MASK (a heartbeat arriving in the KICK cycle counts toward the next round), counter <= 0, go to COLLECT.
  - STARVED(3): starved=1, kick held 0, heartbeats ignored, pending frozen. The state is terminal: the watchdog expires and resets the system.
- Heartbeats on bits not in MASK never affect state.
- The counter does not wrap. Compare uses PERIOD-1 with PERIOD != 0 guaranteed by the arm check.

## Timing
- Kick latency: the last required heartbeat sampled at edge E drives state=KICK after E, so kick is high in the cycle following the heartbeat pulse.
- Minimum kick spacing: 2 cycles (KICK, then at least one COLLECT cycle).
- Window: timeout fires on the PERIODth tick_1us after entering COLLECT. State=STARVED and starved=1 in the cycle following that tick.
- kick and starved are registered outputs (decoded from the state register). They are never asserted together.
- Config writes take effect at the next edge. A RELOAD write in the KICK cycle does not change the value already presented.
- rst asserted mid-operation returns everything to the reset values immediately (asynchronous). The watchdog's own reset is separate.

## Structure
- Shared package: state encoding constants (IDLE/COLLECT/KICK/STARVED) and register address constants (CTRL/MASK/RELOAD/PERIOD). The watchdog slot address is also defined there.
- Single sub-module: wdt_window_timer, holding the 32-bit µs counter plus clear/enable/expire compare. Everything else (FSM, register file, pending logic) lives in the top module.

## Test plan
- Arm checks: arm with MASK=0 -> state stays 0. Set MASK=4'b0011, RELOAD=1000, PERIOD=50, then arm -> state=1.
- Completion: heartbeat[0] then heartbeat[1] 3 cycles later -> kick=1 for one cycle, kick_value=1000, cycle after heartbeat[1]. Pending reads 0 afterwards.
- Window miss: only heartbeat[0] over 50 ticks -> starved=1 one cycle after 50th tick, missed=4'b0010, no further kicks even if heartbeat[1] later arrives.
- Simultaneous events: heartbeat[1] lands on the same edge as the 50th tick with heartbeat[0] pending -> kick, not starved. Heartbeat[0] in the KICK cycle -> pending=4'b0001 afterwards.
- Locking: writes to MASK/PERIOD after arming are ignored on readback. A RELOAD write to 2000 -> next kick_value=2000. Heartbeat[3] (unmasked) has no effect.
- Async reset: rst pulsed mid-COLLECT between clock edges -> state=0, pending=0, kick=0, starved=0 immediately.
